// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_pkg
// Description : Shared opcodes, flag bit positions and command FSM states
//               for the BIP UART ALU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

  // ALU opcodes; the top two bits must be zero for a valid operation
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;

  // Bit positions inside the response flags byte
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_OVF    = 2;
  localparam int FLAG_BAD_OP = 3;

  // Command processor states
  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    TX_LOAD = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational DATA_W-bit ALU with zero/carry/overflow and
//               bad-opcode status.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [7:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              bad_op
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  // Zero-extended add/sub: the extra top bit is carry-out for ADD and
  // borrow (a < b unsigned) for SUB.
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [SH_W-1:0]   w_shamt;

  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = b[SH_W-1:0];

  // Operation select and flag generation
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    bad_op   = 1'b0;
    case (op)
      OP_ADD: begin
        result   = w_sum[DATA_W-1:0];
        carry    = w_sum[DATA_W];
        overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = w_diff[DATA_W-1:0];
        carry    = w_diff[DATA_W];
        overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SRA:  result = $signed(a) >>> w_shamt;
      OP_SRL:  result = a >> w_shamt;
      default: bad_op = 1'b1;
    endcase
  end

  assign zero = !bad_op && (result == '0);

endmodule
`default_nettype wire

// File: rtl/uart_alu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_bridge
// Description : Collects A, B (little-endian, DATA_W/8 bytes each) and an
//               opcode from the UART receiver, evaluates the ALU and returns
//               the result bytes plus an optional flags byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_bridge
  import bip_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int TIMEOUT_TICKS = 100000,
  parameter int SEND_FLAGS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = $clog2(2 * NB + 2);
  localparam int N_RESP = NB + ((SEND_FLAGS != 0) ? 1 : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [IDX_W-1:0]    w_idx_eff;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [7:0]          r_op;
  logic [DATA_W-1:0]   r_result;
  logic [7:0]          r_flags;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_in_get;
  logic                w_expire;
  logic                w_accept;

  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_zero;
  logic                w_alu_carry;
  logic                w_alu_ovf;
  logic                w_alu_bad;
  logic [7:0]          w_flags;

  assign w_in_get  = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_OP);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a        (r_a),
    .b        (r_b),
    .op       (r_op),
    .result   (w_alu_result),
    .zero     (w_alu_zero),
    .carry    (w_alu_carry),
    .overflow (w_alu_ovf),
    .bad_op   (w_alu_bad)
  );

  // Pack ALU status into the response flags byte
  always_comb begin
    w_flags              = '0;
    w_flags[FLAG_ZERO]   = w_alu_zero;
    w_flags[FLAG_CARRY]  = w_alu_carry;
    w_flags[FLAG_OVF]    = w_alu_ovf;
    w_flags[FLAG_BAD_OP] = w_alu_bad;
  end

  // Inter-byte gap watchdog; only armed once a frame has started
  generate
    if (TIMEOUT_TICKS > 0) begin : g_timeout
      localparam int GAP_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
      logic [GAP_W-1:0] r_gap;
      logic             w_gap_active;

      assign w_gap_active = w_in_get && (r_idx != '0);
      // r_gap counts idle cycles since the last byte, so the current cycle
      // is the TIMEOUT_TICKS-th one when it reads TIMEOUT_TICKS-1.
      assign w_expire = w_gap_active && (r_gap == GAP_W'(TIMEOUT_TICKS - 1));

      // Count idle cycles; restart on any byte, expiry or leaving the frame
      always_ff @(posedge clk) begin
        if (reset || !w_gap_active || rx_done_tick || w_expire) begin
          r_gap <= '0;
        end else begin
          r_gap <= r_gap + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign w_expire = 1'b0;
    end
  endgenerate

  // FSM state and byte index register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= GET_A;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state, byte index and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    tx_start    = 1'b0;
    busy        = 1'b0;
    tx_data     = '0;
    // An expiring frame is dropped first so a byte in the same cycle
    // becomes byte 0 of a fresh frame.
    w_idx_eff   = w_expire ? '0 : r_idx;
    w_idx_inc   = w_idx_eff + IDX_W'(1);

    case (r_state)
      GET_A, GET_B, GET_OP: begin
        if (w_expire) begin
          w_state_nxt = GET_A;
          w_idx_nxt   = '0;
        end
        if (rx_done_tick) begin
          w_accept = 1'b1;
          if (w_idx_eff == IDX_W'(2 * NB)) begin
            w_state_nxt = EXEC;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = w_idx_inc;
            if (w_idx_inc < IDX_W'(NB)) begin
              w_state_nxt = GET_A;
            end else if (w_idx_inc < IDX_W'(2 * NB)) begin
              w_state_nxt = GET_B;
            end else begin
              w_state_nxt = GET_OP;
            end
          end
        end
      end
      EXEC: begin
        busy        = 1'b1;
        w_state_nxt = TX_LOAD;
        w_idx_nxt   = '0;
      end
      TX_LOAD: begin
        busy        = 1'b1;
        tx_start    = 1'b1;
        w_state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        busy = 1'b1;
        if (tx_done_tick) begin
          if (r_idx == IDX_W'(N_RESP - 1)) begin
            w_state_nxt = GET_A;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = TX_LOAD;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = GET_A;
        w_idx_nxt   = '0;
      end
    endcase

    // Response byte selected by the index; stable across TX_LOAD/TX_WAIT
    if ((r_state == TX_LOAD) || (r_state == TX_WAIT)) begin
      for (int i = 0; i < NB; i++) begin
        if (r_idx == IDX_W'(i)) begin
          tx_data = r_result[i*8 +: 8];
        end
      end
      if ((SEND_FLAGS != 0) && (r_idx == IDX_W'(NB))) begin
        tx_data = r_flags;
      end
    end
  end

  // Operand capture, result registration and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_expire;
      r_overrun   <= rx_done_tick && !w_in_get;
      if (w_accept) begin
        for (int i = 0; i < NB; i++) begin
          if (w_idx_eff == IDX_W'(i)) begin
            r_a[i*8 +: 8] <= rx_data;
          end
          if (w_idx_eff == IDX_W'(NB + i)) begin
            r_b[i*8 +: 8] <= rx_data;
          end
        end
        if (w_idx_eff == IDX_W'(2 * NB)) begin
          r_op <= rx_data;
        end
      end
      if (r_state == EXEC) begin
        r_result <= w_alu_result;
        r_flags  <= w_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_bridge
// Description : Scoreboard bench for uart_alu_bridge (DATA_W=16, timeout 50)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int txs_cnt  = 0;
  int dly_lo   = 2;
  int dly_hi   = 5;
  bit tx_abort = 1'b0;

  logic [7:0] exp_q[$];
  bit         last_q[$];

  always #5 clk = ~clk;

  uart_alu_bridge #(
    .DATA_W        (16),
    .TIMEOUT_TICKS (50),
    .SEND_FLAGS    (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: response = result bytes (LSB first) then flags byte
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] op,
                                output logic [15:0] r, output logic [7:0] f);
    int ua, ub, sa, sb, t;
    bit c, v, bad;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; bad = 1'b0; t = 0; r = '0;
    case (op)
      8'h20: begin t = ua + ub; r = 16'(t); c = (t > 65535);
                   v = (sa + sb > 32767) || (sa + sb < -32768); end
      8'h22: begin t = ua - ub; r = 16'(t); c = (ua < ub);
                   v = (sa - sb > 32767) || (sa - sb < -32768); end
      8'h24: r = a & b;
      8'h25: r = a | b;
      8'h26: r = a ^ b;
      8'h27: r = ~(a | b);
      8'h03: begin t = sa >>> b[3:0]; r = 16'(t); end
      8'h02: begin t = ua >> b[3:0]; r = 16'(t); end
      default: begin r = '0; bad = 1'b1; end
    endcase
    f = {4'b0000, bad, v, c, (!bad && r == 16'h0000)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (!busy && exp_q.size() == 0) return;
      @(negedge clk);
    end
    fail_now("wait_idle");
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    logic [15:0] r;
    logic [7:0]  f;
    logic [7:0]  bytes [5];
    wait_idle();
    model(a, b, op, r, f);
    exp_q.push_back(r[7:0]);  last_q.push_back(1'b0);
    exp_q.push_back(r[15:8]); last_q.push_back(1'b0);
    exp_q.push_back(f);       last_q.push_back(1'b1);
    bytes = '{a[7:0], a[15:8], b[7:0], b[15:8], op};
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      if (i < 4) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("busy_after_opcode", {31'd0, busy}, 32'd1);
  endtask

  // Pulse counters for the one-cycle status outputs
  always @(posedge clk) begin
    #1;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (tx_start)  txs_cnt++;
  end

  // Monitor + transmitter emulation: pop and compare each started byte
  initial begin
    logic [7:0] e;
    bit         l;
    forever begin
      @(posedge clk);
      #1;
      while (tx_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx_start: got %0h expected none", tx_data);
          l = 1'b1;
        end else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, e});
        end
        repeat ($urandom_range(dly_lo, dly_hi)) @(negedge clk);
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
        if (tx_abort) break;
        check("busy_after_done", {31'd0, busy}, {31'd0, !l});
        check("tx_start_after_done", {31'd0, tx_start}, {31'd0, !l});
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] ops [8];
    int f0, o0, s0;
    logic [7:0] op;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    repeat (3) @(negedge clk);
    check("rst_tx_start",  {31'd0, tx_start},  32'd0);
    check("rst_tx_data",   {24'd0, tx_data},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed frames
    send_frame(16'h1234, 16'h0F0F, 8'h20);
    send_frame(16'h0001, 16'h0002, 8'h22);
    send_frame(16'h7FFF, 16'h0001, 8'h20);
    send_frame(16'h8000, 16'h0004, 8'h03);
    send_frame(16'h0000, 16'h0000, 8'h3F);
    send_frame(16'hFFFF, 16'hFFFF, 8'h24);
    send_frame(16'h8000, 16'h0001, 8'h22);

    // Timeout: partial frame then a long gap
    wait_idle();
    f0 = fe_cnt; s0 = txs_cnt;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (60) @(negedge clk);
    check("frame_err_pulses", fe_cnt - f0, 32'd1);
    check("no_tx_on_timeout", txs_cnt - s0, 32'd0);
    send_frame(16'h00FF, 16'h0001, 8'h20);

    // Overrun: bytes during the response are dropped
    wait_idle();
    o0 = ov_cnt;
    send_frame(16'hABCD, 16'h1111, 8'h26);
    send_byte(8'h5A);
    repeat (3) @(negedge clk);
    send_byte(8'hA5);
    wait_idle();
    repeat (2) @(negedge clk);
    check("overrun_pulses", ov_cnt - o0, 32'd2);
    send_frame(16'h0F00, 16'h00F0, 8'h25);

    // Reset during TX_WAIT
    wait_idle();
    dly_lo = 12; dly_hi = 12;
    send_frame(16'h1111, 16'h2222, 8'h20);
    for (int k = 0; k <= 50; k++) begin
      if (k == 50) begin fail_now("wait_tx_start"); break; end
      @(posedge clk);
      #1;
      if (tx_start) break;
    end
    tx_abort = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_mid_busy",     {31'd0, busy},     32'd0);
    s0 = txs_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_tx_after_reset", txs_cnt - s0, 32'd0);
    exp_q.delete();
    last_q.delete();
    tx_abort = 1'b0;
    dly_lo = 2; dly_hi = 5;
    send_frame(16'h4321, 16'h1234, 8'h22);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) >= 8) op = 8'($urandom);
      else op = ops[$urandom_range(0, 7)];
      send_frame(16'($urandom), 16'($urandom), op);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("total_frame_err", fe_cnt, 32'd1);
    check("total_overrun", ov_cnt, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_alu_bridge.md
# uart_alu_bridge

Byte-stream command processor between the UART receiver and transmitter in the BIP test system. It collects operand A, operand B and an opcode from the `rx_done_tick`/`dout` byte stream, evaluates a DATA_W-bit ALU operation and returns the result plus a flags byte through the `tx_start`/`tx_done_tick` handshake. It generalises the fixed 8-bit operand interface with:

- wider multi-byte operands;
- status flags;
- an inter-byte timeout;
- overrun reporting.

## Interface
Parameters:
- DATA_W, 16, operand/result width; multiple of 8, range 8..64; NB = DATA_W/8 bytes per operand.
- TIMEOUT_TICKS, 100000, maximum `clk` cycles between bytes of one frame; 0 disables the timeout.
- SEND_FLAGS, 1, when 1 a flags byte follows the result bytes.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe: rx_data is valid.
- rx_data  in  8  received byte.
- tx_done_tick  in  1  one-cycle strobe: transmitter finished the current byte.
- tx_start  out  1  one-cycle strobe: start sending tx_data.
- tx_data  out  8  byte to send; held stable from tx_start until tx_done_tick.
- busy  out  1  high from EXEC until the last tx_done_tick of the response.
- frame_err  out  1  one-cycle pulse on inter-byte timeout.
- overrun  out  1  one-cycle pulse when a byte arrives while busy; that byte is discarded.

Reset values: tx_start=0, tx_data=0, busy=0, frame_err=0, overrun=0. Reset clears all registers and puts the FSM in GET_A with byte count 0.

## Operation
Frame format: NB bytes of A, NB bytes of B (both little-endian), then 1 opcode byte.

FSM states:
- GET_A: accept rx bytes into A; after NB bytes go to GET_B.
- GET_B: same for B; after NB bytes go to GET_OP.
- GET_OP: the next byte is latched as the opcode; go to EXEC.
- EXEC: register the result and flags; go to TX_LOAD.
- TX_LOAD: drive tx_data with the next response byte, pulse tx_start; go to TX_WAIT.
- TX_WAIT: on tx_done_tick go to TX_LOAD if bytes remain, otherwise to GET_A.

Response byte order: result LSB first (NB bytes), then the flags byte if SEND_FLAGS=1.

Opcodes (valid only when byte[7:6]=00; byte[5:0] selects the op):
- ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- SRA 0x03, SRL 0x02: A shifted right by B[$clog2(DATA_W)-1:0].
- Any other value: result=0 and bad_op=1.

Flags byte:
- bit0 zero: result==0, valid ops only.
- bit1 carry: ADD carry-out; for SUB, the borrow (A<B unsigned); 0 for all other ops.
- bit2 overflow: signed two's-complement overflow for ADD/SUB; otherwise 0.
- bit3 bad_op.
- bits7:4 are 0.

Boundary rules:
- Timeout: a gap counter runs while in GET_A/GET_B/GET_OP with at least one frame byte received. When the gap reaches TIMEOUT_TICKS cycles without rx_done_tick:
  - pulse frame_err;
  - discard the partial frame and return to GET_A with count 0.
  - A byte arriving in the same cycle as expiry counts as the first byte of a new frame.
- Overrun: rx_done_tick during EXEC/TX_LOAD/TX_WAIT pulses overrun; the byte is dropped, with no frame effect.
- Reset mid-frame or mid-response: immediate return to the reset state. No further tx_start; a tx_done_tick arriving later is ignored.
- tx_done_tick outside TX_WAIT is ignored.

## Timing
- Opcode byte rx_done_tick in cycle n: EXEC in n+1, tx_start in n+2, busy high from n+1.
- Each subsequent tx_start comes 1 cycle after the previous tx_done_tick.
- busy falls in the cycle after the final tx_done_tick. A byte accepted in that cycle is frame byte 0.
- ALU path is combinational from the A/B/op registers and is registered in EXEC; no other pipeline stages.

## Structure
- Shared package bip_pkg holds:
  - opcode localparams;
  - flag bit indices;
  - the state enum/localparams (GET_A, GET_B, GET_OP, EXEC, TX_LOAD, TX_WAIT).
- One sub-module: alu_core #(DATA_W). Combinational; inputs A, B, op; outputs result, zero, carry, overflow, bad_op. Reusable by a future direct-LED ALU top.
- Counters: byte index of $clog2(2*NB+2) bits; gap counter sized for TIMEOUT_TICKS.

## Test plan
- DATA_W=16, ADD: rx 34 12 0F 0F 20 -> tx 43 21 00; busy falls after the third tx_done_tick.
- SUB: rx 01 00 02 00 22 -> tx FF FF 02 (borrow set, no overflow).
- Overflow: 0x7FFF+0x0001, rx FF 7F 01 00 20 -> tx 00 80 04. SRA: A=0x8000, B=4 -> tx 00 F8 00.
- Bad opcode 0x3F with A=B=0 -> tx 00 00 08. Zero flag clear.
- TIMEOUT_TICKS=50: rx 3 bytes, then a 60-cycle gap -> single frame_err pulse, no tx. A following full ADD frame returns the correct result.
- rx byte during TX_WAIT -> overrun pulse and the response is unchanged. Reset asserted mid-TX_WAIT -> tx_start stays 0 and busy=0 next cycle; the next frame is processed correctly.
